multi_timeout_checker: RTL and testbench

// - N-channel transfer watchdog between the TAP bridge and the AHB/APB bus masters; successor to the single-channel checker.
// - Each channel is armed by a start pulse and closed by a done pulse.
// - Each channel has its own limit, latched at start.
// - Reports a sticky per-channel timeout, an aggregate irq and the lowest timed-out channel. Software clears each channel.

---
 rtl/timeout_pkg.sv | 12 +
 rtl/timeout_channel.sv | 79 +++++++
 rtl/multi_timeout_checker.sv | 75 +++++++
 tb/tb_multi_timeout_checker.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/timeout_pkg.sv
// Shared types and constants for the multi-channel transfer watchdog.
package timeout_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      TIMEOUT = 2'd2
   } state_e;

   localparam int MAX_CH = 16;

endpackage

// File: rtl/timeout_channel.sv
// One watchdog channel: FSM, elapsed-tick counter and the limit latched at start.
module timeout_channel #(
   parameter int CNT_W = 10
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             start,
   input  logic             done,
   input  logic             clr,
   input  logic [CNT_W-1:0] limit,
   output logic             busy,
   output logic             timeout
);
   import timeout_pkg::*;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   lim_q, lim_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lim_d   = lim_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = BUSY;
               count_d = '0;
               lim_d   = limit;
            end
         end
         BUSY: begin
            // A start always wins: a new transfer supersedes a done or an expiry.
            if (start) begin
               count_d = '0;
               lim_d   = limit;
            end else if (done) begin
               state_d = IDLE;
               count_d = '0;
            end else if (tick) begin
               if (count_q == lim_q) state_d = TIMEOUT;
               else                  count_d = count_q + CNT_W'(1);
            end
         end
         TIMEOUT: begin
            if (clr) begin
               state_d = IDLE;
               count_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d    = (state_d == BUSY);
      timeout_d = (state_d == TIMEOUT);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         lim_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         lim_q     <= lim_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: rtl/multi_timeout_checker.sv
// N-channel transfer watchdog with sticky per-channel timeouts, aggregate irq and lowest-channel encode.
// Optional shared tick prescaler enabled by defining TIMEOUT_PRESCALE_EN.
module multi_timeout_checker #(
   parameter int N_CH     = 2,
   parameter int CNT_W    = 10,
   parameter int PRESCALE = 16
) (
   input  logic                                      sys_clk,
   input  logic                                      rst_n,
   input  logic [N_CH-1:0]                           start_i,
   input  logic [N_CH-1:0]                           done_i,
   input  logic [N_CH-1:0]                           clr_i,
   input  logic [N_CH*CNT_W-1:0]                     limit_i,
   output logic [N_CH-1:0]                           busy_o,
   output logic [N_CH-1:0]                           timeout_o,
   output logic                                      irq_o,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_ch_o,
   output logic                                      first_vld_o
);
   import timeout_pkg::*;

   localparam int FW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic tick;

`ifdef TIMEOUT_PRESCALE_EN
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0] pre_q, pre_d;

   always_comb begin
      pre_d = (pre_q == PRE_W'(PRESCALE - 1)) ? '0 : pre_q + PRE_W'(1);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) pre_q <= '0;
      else        pre_q <= pre_d;
   end

   assign tick = (pre_q == PRE_W'(PRESCALE - 1));
`else
   logic unused_prescale;

   assign unused_prescale = (PRESCALE > 1);
   assign tick            = 1'b1;
`endif

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      timeout_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .sys_clk (sys_clk),
         .rst_n   (rst_n),
         .tick    (tick),
         .start   (start_i[k]),
         .done    (done_i[k]),
         .clr     (clr_i[k]),
         .limit   (limit_i[k*CNT_W +: CNT_W]),
         .busy    (busy_o[k]),
         .timeout (timeout_o[k])
      );
   end

   assign irq_o       = |timeout_o;
   assign first_vld_o = irq_o;

   // Scan from the top down so the lowest timed-out index is the last one written.
   always_comb begin
      first_ch_o = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (timeout_o[i]) first_ch_o = FW'(i);
      end
   end

endmodule

// File: tb/tb_multi_timeout_checker.sv
// Bench for multi_timeout_checker (N_CH=2, CNT_W=10, no prescaler): directed table, corner sequences, random vs model.
module tb_multi_timeout_checker;

   localparam int N_CH  = 2;
   localparam int CNT_W = 10;

   logic                   sys_clk = 1'b0;
   logic                   rst_n;
   logic [N_CH-1:0]        start_i, done_i, clr_i;
   logic [N_CH*CNT_W-1:0]  limit_i;
   logic [N_CH-1:0]        busy_o, timeout_o;
   logic                   irq_o, first_vld_o;
   logic [0:0]             first_ch_o;

   int checks = 0;
   int errors = 0;

   multi_timeout_checker #(.N_CH(N_CH), .CNT_W(CNT_W), .PRESCALE(16)) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .done_i      (done_i),
      .clr_i       (clr_i),
      .limit_i     (limit_i),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o),
      .irq_o       (irq_o),
      .first_ch_o  (first_ch_o),
      .first_vld_o (first_vld_o)
   );

   always #5 sys_clk = ~sys_clk;

   // Reference model: a channel times out at the edge that lies lim+1 edges after its last start.
   int     m_st  [N_CH];   // 0 idle, 1 busy, 2 timed out
   longint m_t0  [N_CH];
   int     m_lim [N_CH];
   longint ecount = 0;

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_st[c] = 0; m_t0[c] = 0; m_lim[c] = 0;
      end
   endtask

   task automatic model_edge();
      ecount++;
      for (int c = 0; c < N_CH; c++) begin
         if (m_st[c] == 0) begin
            if (start_i[c]) begin
               m_st[c] = 1; m_t0[c] = ecount; m_lim[c] = int'(limit_i[c*CNT_W +: CNT_W]);
            end
         end else if (m_st[c] == 1) begin
            if (start_i[c]) begin
               m_t0[c] = ecount; m_lim[c] = int'(limit_i[c*CNT_W +: CNT_W]);
            end else if (done_i[c]) begin
               m_st[c] = 0;
            end else if (ecount == m_t0[c] + longint'(m_lim[c]) + 1) begin
               m_st[c] = 2;
            end
         end else if (clr_i[c]) begin
            m_st[c] = 0;
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: actual=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      logic [N_CH-1:0] eb, et;
      int ef;
      eb = '0; et = '0; ef = 0;
      for (int c = N_CH - 1; c >= 0; c--) begin
         eb[c] = (m_st[c] == 1);
         et[c] = (m_st[c] == 2);
         if (m_st[c] == 2) ef = c;
      end
      chk({tag, ".busy"},    32'(busy_o),      32'(eb));
      chk({tag, ".timeout"}, 32'(timeout_o),   32'(et));
      chk({tag, ".irq"},     32'(irq_o),       32'(|et));
      chk({tag, ".first"},   32'(first_ch_o),  32'(ef));
      chk({tag, ".vld"},     32'(first_vld_o), 32'(|et));
   endtask

   task automatic step(input logic [1:0] s, input logic [1:0] d, input logic [1:0] c,
                       input logic [9:0] l0, input logic [9:0] l1, input string tag);
      start_i = s; done_i = d; clr_i = c; limit_i = {l1, l0};
      @(posedge sys_clk);
      model_edge();
      #1;
      compare_model(tag);
   endtask

   typedef struct {
      logic [1:0] s, d, c;
      logic [9:0] l0, l1;
      logic [1:0] eb, et;
      logic       ef;
   } vec_t;

   vec_t tbl [11];

   initial begin
      tbl[0]  = '{s:2'b01, d:2'b00, c:2'b00, l0:10'd2, l1:10'd0, eb:2'b01, et:2'b00, ef:1'b0};
      tbl[1]  = '{s:2'b00, d:2'b00, c:2'b00, l0:10'd9, l1:10'd0, eb:2'b01, et:2'b00, ef:1'b0};
      tbl[2]  = '{s:2'b00, d:2'b00, c:2'b00, l0:10'd9, l1:10'd0, eb:2'b01, et:2'b00, ef:1'b0};
      tbl[3]  = '{s:2'b00, d:2'b00, c:2'b00, l0:10'd2, l1:10'd0, eb:2'b00, et:2'b01, ef:1'b0};
      tbl[4]  = '{s:2'b11, d:2'b00, c:2'b00, l0:10'd2, l1:10'd0, eb:2'b10, et:2'b01, ef:1'b0};
      tbl[5]  = '{s:2'b00, d:2'b00, c:2'b00, l0:10'd2, l1:10'd0, eb:2'b00, et:2'b11, ef:1'b0};
      tbl[6]  = '{s:2'b00, d:2'b00, c:2'b01, l0:10'd2, l1:10'd0, eb:2'b00, et:2'b10, ef:1'b1};
      tbl[7]  = '{s:2'b10, d:2'b00, c:2'b10, l0:10'd2, l1:10'd0, eb:2'b00, et:2'b00, ef:1'b0};
      tbl[8]  = '{s:2'b11, d:2'b11, c:2'b00, l0:10'd2, l1:10'd4, eb:2'b11, et:2'b00, ef:1'b0};
      tbl[9]  = '{s:2'b01, d:2'b11, c:2'b00, l0:10'd2, l1:10'd4, eb:2'b01, et:2'b00, ef:1'b0};
      tbl[10] = '{s:2'b00, d:2'b01, c:2'b00, l0:10'd2, l1:10'd4, eb:2'b00, et:2'b00, ef:1'b0};

      rst_n = 1'b0; start_i = '0; done_i = '0; clr_i = '0; limit_i = '0;
      model_reset();
      repeat (3) @(posedge sys_clk);
      #1;
      chk("reset.busy", 32'(busy_o), 32'd0);
      chk("reset.timeout", 32'(timeout_o), 32'd0);
      chk("reset.irq", 32'(irq_o), 32'd0);
      chk("reset.first", 32'(first_ch_o), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         step(tbl[i].s, tbl[i].d, tbl[i].c, tbl[i].l0, tbl[i].l1, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.busy_exp", i), 32'(busy_o), 32'(tbl[i].eb));
         chk($sformatf("tbl%0d.to_exp", i), 32'(timeout_o), 32'(tbl[i].et));
         chk($sformatf("tbl%0d.first_exp", i), 32'(first_ch_o), 32'(tbl[i].ef));
         chk($sformatf("tbl%0d.irq_exp", i), 32'(irq_o), 32'(|tbl[i].et));
      end

      // Done on the expiry edge wins.
      step(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, "dexp.start");
      for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 2'b00, 10'd5, 10'd0, "dexp.run");
      chk("dexp.busy_before", 32'(busy_o[0]), 32'd1);
      step(2'b00, 2'b01, 2'b00, 10'd5, 10'd0, "dexp.done");
      chk("dexp.busy_after", 32'(busy_o[0]), 32'd0);
      chk("dexp.timeout", 32'(timeout_o[0]), 32'd0);

      // Plain expiry at start edge + lim + 1.
      step(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, "exp.start");
      for (int i = 0; i < 5; i++) step(2'b00, 2'b00, 2'b00, 10'd5, 10'd0, "exp.run");
      chk("exp.early", 32'(timeout_o[0]), 32'd0);
      step(2'b00, 2'b00, 2'b00, 10'd5, 10'd0, "exp.edge");
      chk("exp.timeout", 32'(timeout_o[0]), 32'd1);
      step(2'b00, 2'b00, 2'b01, 10'd5, 10'd0, "exp.clr");

      // Re-arm latches the new limit; later limit changes are ignored.
      step(2'b01, 2'b00, 2'b00, 10'd3, 10'd0, "rearm.start1");
      step(2'b00, 2'b00, 2'b00, 10'd3, 10'd0, "rearm.run");
      step(2'b01, 2'b00, 2'b00, 10'd8, 10'd0, "rearm.start2");
      for (int i = 0; i < 8; i++) step(2'b00, 2'b00, 2'b00, 10'd1, 10'd0, "rearm.run2");
      chk("rearm.early", 32'(timeout_o[0]), 32'd0);
      step(2'b00, 2'b00, 2'b00, 10'd1, 10'd0, "rearm.edge");
      chk("rearm.timeout", 32'(timeout_o[0]), 32'd1);
      step(2'b00, 2'b00, 2'b01, 10'd1, 10'd0, "rearm.clr");

      // Maximum limit on channel 1.
      step(2'b10, 2'b00, 2'b00, 10'd0, 10'd1023, "max.start");
      for (int i = 0; i < 1023; i++) step(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, "max.run");
      chk("max.early", 32'(timeout_o[1]), 32'd0);
      step(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, "max.edge");
      chk("max.timeout", 32'(timeout_o[1]), 32'd1);
      chk("max.first", 32'(first_ch_o), 32'd1);
      step(2'b00, 2'b00, 2'b10, 10'd0, 10'd0, "max.clr");

      // Asynchronous reset mid-transfer.
      step(2'b11, 2'b00, 2'b00, 10'd0, 10'd50, "arst.start");
      step(2'b00, 2'b00, 2'b00, 10'd0, 10'd50, "arst.run");
      chk("arst.pre_timeout", 32'(timeout_o), 32'b01);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.busy", 32'(busy_o), 32'd0);
      chk("arst.timeout", 32'(timeout_o), 32'd0);
      chk("arst.irq", 32'(irq_o), 32'd0);
      model_reset();
      @(negedge sys_clk);
      rst_n = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         logic [1:0] s, d, c;
         for (int b = 0; b < 2; b++) begin
            s[b] = ($urandom_range(0, 7) == 0);
            d[b] = ($urandom_range(0, 7) == 0);
            c[b] = ($urandom_range(0, 5) == 0);
         end
         step(s, d, c, 10'($urandom_range(0, 12)), 10'($urandom_range(0, 12)), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
